// File: rtl/hyper_titan_ddr_arb.sv
// Two-requester weighted round-robin arbiter for the shared DDR3 command/write-data port.
// The grant is held from command acceptance through the wlast handshake, so write bursts never interleave.
module hyper_titan_ddr_arb #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 128,
    parameter int LEN_W    = 8,
    parameter int WEIGHT_0 = 1,
    parameter int WEIGHT_1 = 2,
    parameter int CNT_W    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            m_cmd_valid_i,
    output logic [1:0]            m_cmd_ready_o,
    input  logic [2*ADDR_W-1:0]   m_cmd_addr_i,
    input  logic [1:0]            m_cmd_write_i,
    input  logic [2*LEN_W-1:0]    m_cmd_len_i,
    input  logic [1:0]            m_wvalid_i,
    output logic [1:0]            m_wready_o,
    input  logic [2*DATA_W-1:0]   m_wdata_i,
    input  logic [1:0]            m_wlast_i,
    output logic                  s_cmd_valid_o,
    input  logic                  s_cmd_ready_i,
    output logic [ADDR_W-1:0]     s_cmd_addr_o,
    output logic                  s_cmd_write_o,
    output logic [LEN_W-1:0]      s_cmd_len_o,
    output logic                  s_cmd_id_o,
    output logic                  s_wvalid_o,
    input  logic                  s_wready_i,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic                  s_wlast_o,
    output logic                  gnt_o,
    output logic                  busy_o
);

    // A zero weight behaves as a weight of one.
    localparam logic [CNT_W:0] W0 = (WEIGHT_0 == 0) ? (CNT_W+1)'(1) : (CNT_W+1)'(WEIGHT_0);
    localparam logic [CNT_W:0] W1 = (WEIGHT_1 == 0) ? (CNT_W+1)'(1) : (CNT_W+1)'(WEIGHT_1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

    state_t             state_reg, state_next;
    logic               gnt_reg, gnt_next;
    logic               pref_reg, pref_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               done;
    logic [CNT_W:0]     streak;
    logic [CNT_W:0]     weight_g;

    logic [ADDR_W-1:0]  addr_arr  [2];
    logic [LEN_W-1:0]   len_arr   [2];
    logic [DATA_W-1:0]  wdata_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign addr_arr[gi]      = m_cmd_addr_i[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]       = m_cmd_len_i[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi]     = m_wdata_i[gi*DATA_W +: DATA_W];
            assign m_cmd_ready_o[gi] = (state_reg == CMD) && (gnt_reg == 1'(gi)) && s_cmd_ready_i;
            assign m_wready_o[gi]    = (state_reg == WDATA) && (gnt_reg == 1'(gi)) && s_wready_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            gnt_reg   <= 1'b0;
            pref_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            pref_reg  <= pref_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        pref_next     = pref_reg;
        cnt_next      = cnt_reg;
        done          = 1'b0;
        s_cmd_valid_o = 1'b0;
        s_cmd_addr_o  = '0;
        s_cmd_write_o = 1'b0;
        s_cmd_len_o   = '0;
        s_cmd_id_o    = 1'b0;
        s_wvalid_o    = 1'b0;
        s_wdata_o     = '0;
        s_wlast_o     = 1'b0;
        streak        = '0;
        weight_g      = gnt_reg ? W1 : W0;

        case (state_reg)
            IDLE: begin
                if (|m_cmd_valid_i) begin
                    gnt_next   = (&m_cmd_valid_i) ? pref_reg : m_cmd_valid_i[1];
                    state_next = CMD;
                end
            end
            CMD: begin
                s_cmd_valid_o = m_cmd_valid_i[gnt_reg];
                s_cmd_addr_o  = addr_arr[gnt_reg];
                s_cmd_write_o = m_cmd_write_i[gnt_reg];
                s_cmd_len_o   = len_arr[gnt_reg];
                s_cmd_id_o    = gnt_reg;
                if (m_cmd_valid_i[gnt_reg] && s_cmd_ready_i) begin
                    if (m_cmd_write_i[gnt_reg]) begin
                        state_next = WDATA;
                    end else begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end
                end
            end
            WDATA: begin
                s_wvalid_o = m_wvalid_i[gnt_reg];
                s_wdata_o  = wdata_arr[gnt_reg];
                s_wlast_o  = m_wlast_i[gnt_reg];
                // Only wlast ends the burst; the beat count is never compared with len.
                if (m_wvalid_i[gnt_reg] && s_wready_i && m_wlast_i[gnt_reg]) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (done) begin
            streak = (gnt_reg == pref_reg) ? ({1'b0, cnt_reg} + (CNT_W+1)'(1)) : (CNT_W+1)'(1);
            if (streak >= weight_g) begin
                pref_next = ~gnt_reg;
                cnt_next  = '0;
            end else begin
                pref_next = gnt_reg;
                cnt_next  = streak[CNT_W-1:0];
            end
        end
    end

    assign gnt_o  = gnt_reg;
    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_hyper_titan_ddr_arb.sv
// Bench for hyper_titan_ddr_arb: fixed vector table, hand-written corner sequences,
// then randomized transactions checked against a transaction-level preference model.
module tb_hyper_titan_ddr_arb;

    localparam int ADDR_W   = 28;
    localparam int DATA_W   = 128;
    localparam int LEN_W    = 8;
    localparam int WEIGHT_0 = 1;
    localparam int WEIGHT_1 = 2;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [1:0]          cmd_valid, cmd_write, wvalid, wlast;
    logic [ADDR_W-1:0]   addr_m  [2];
    logic [LEN_W-1:0]    len_m   [2];
    logic [DATA_W-1:0]   wdata_m [2];
    logic                s_cmd_ready, s_wready;

    logic [1:0]          m_cmd_ready_o, m_wready_o;
    logic                s_cmd_valid_o, s_cmd_write_o, s_cmd_id_o;
    logic [ADDR_W-1:0]   s_cmd_addr_o;
    logic [LEN_W-1:0]    s_cmd_len_o;
    logic                s_wvalid_o, s_wlast_o, gnt_o, busy_o;
    logic [DATA_W-1:0]   s_wdata_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int txn_no    = 0;
    logic drop_phase = 1'b0;

    // Reference model: preferred requester and length of its current winning streak.
    logic pref_m;
    int   streak_m;

    always #5 clk_i = ~clk_i;

    hyper_titan_ddr_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .WEIGHT_0(WEIGHT_0), .WEIGHT_1(WEIGHT_1), .CNT_W(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cmd_valid_i(cmd_valid), .m_cmd_ready_o(m_cmd_ready_o),
        .m_cmd_addr_i({addr_m[1], addr_m[0]}), .m_cmd_write_i(cmd_write),
        .m_cmd_len_i({len_m[1], len_m[0]}),
        .m_wvalid_i(wvalid), .m_wready_o(m_wready_o),
        .m_wdata_i({wdata_m[1], wdata_m[0]}), .m_wlast_i(wlast),
        .s_cmd_valid_o(s_cmd_valid_o), .s_cmd_ready_i(s_cmd_ready),
        .s_cmd_addr_o(s_cmd_addr_o), .s_cmd_write_o(s_cmd_write_o),
        .s_cmd_len_o(s_cmd_len_o), .s_cmd_id_o(s_cmd_id_o),
        .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready),
        .s_wdata_o(s_wdata_o), .s_wlast_o(s_wlast_o),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    // A granted requester that drops its command valid must not release the port.
    assert property (@(posedge clk_i) disable iff (rst_i) drop_phase |=> busy_o)
        else $error("FAIL drop_valid: arbiter left CMD on a dropped valid");

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic int weight_of(input logic g);
        int w;
        w = g ? WEIGHT_1 : WEIGHT_0;
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic predict(input logic [1:0] vm);
        return (vm == 2'b11) ? pref_m : vm[1];
    endfunction

    // A requester keeps preference until it has won weight_of() transactions in a row.
    task automatic model_done(input logic g);
        int c;
        c = (g == pref_m) ? streak_m + 1 : 1;
        if (c >= weight_of(g)) begin
            pref_m   = !g;
            streak_m = 0;
        end else begin
            pref_m   = g;
            streak_m = c;
        end
    endtask

    task automatic model_reset();
        pref_m   = 1'b0;
        streak_m = 0;
    endtask

    // Runs one full transaction starting at a negedge with the DUT in IDLE.
    task automatic run_txn(input logic [1:0] vm, input logic wr, input int stall,
                           input int beats, input logic g);
        logic       rdy;
        logic [1:0] exp_wr;
        int         tries;
        for (int r = 0; r < 2; r++) begin
            if (vm[r] && !cmd_valid[r]) begin
                addr_m[r]    = ADDR_W'($urandom);
                len_m[r]     = LEN_W'($urandom);
                cmd_write[r] = 1'($urandom);
            end
        end
        cmd_write[g] = wr;
        cmd_valid    = vm;
        wvalid[!g]   = 1'($urandom);
        s_cmd_ready  = 1'b0;
        s_wready     = 1'b0;
        @(negedge clk_i);
        chk("gnt", gnt_o, g);
        chk("cmd_valid", s_cmd_valid_o, 1'b1);
        chk("cmd_id", s_cmd_id_o, g);
        chk("cmd_addr", s_cmd_addr_o, addr_m[g]);
        chk("cmd_len", s_cmd_len_o, len_m[g]);
        chk("cmd_write", s_cmd_write_o, wr);
        chk("cmd_ready_wait", m_cmd_ready_o, 2'b00);
        chk("wready_in_cmd", m_wready_o, 2'b00);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            chk("stall_valid", s_cmd_valid_o, 1'b1);
            chk("stall_addr", s_cmd_addr_o, addr_m[g]);
            chk("stall_ready", m_cmd_ready_o, 2'b00);
            chk("stall_gnt", gnt_o, g);
        end
        s_cmd_ready = 1'b1;
        #1;
        chk("cmd_ready", m_cmd_ready_o, g ? 2'b10 : 2'b01);
        @(negedge clk_i);
        cmd_valid[g] = 1'b0;
        s_cmd_ready  = 1'b0;
        if (wr) begin
            #1;
            chk("busy_wdata", busy_o, 1'b1);
            chk("cmd_valid_wdata", s_cmd_valid_o, 1'b0);
            for (int b = 0; b < beats; b++) begin
                wdata_m[g] = {$urandom, $urandom, $urandom, $urandom};
                wvalid[g]  = 1'b1;
                wlast[g]   = (b == beats - 1);
                wvalid[!g] = 1'($urandom);
                rdy   = 1'b0;
                tries = 0;
                while (!rdy) begin
                    rdy      = (tries >= 3) ? 1'b1 : 1'($urandom);
                    s_wready = rdy;
                    exp_wr   = rdy ? (g ? 2'b10 : 2'b01) : 2'b00;
                    #1;
                    chk("s_wvalid", s_wvalid_o, 1'b1);
                    chk("s_wdata", s_wdata_o, wdata_m[g]);
                    chk("s_wlast", s_wlast_o, wlast[g]);
                    chk("m_wready", m_wready_o, exp_wr);
                    chk("gnt_hold", gnt_o, g);
                    @(negedge clk_i);
                    tries++;
                end
            end
            wvalid   = 2'b00;
            wlast    = 2'b00;
            s_wready = 1'b0;
        end
        wvalid = 2'b00;
        #1;
        chk("busy_done", busy_o, 1'b0);
        chk("idle_cmd_valid", s_cmd_valid_o, 1'b0);
        model_done(g);
        $display("txn %0d: vm=%b gnt=%0d wr=%0d stall=%0d beats=%0d", txn_no, vm, g, wr, stall, beats);
        txn_no++;
    endtask

    typedef struct {
        logic [1:0] vm;
        logic       wr;
        int         stall;
        int         beats;
        logic       exp_g;
    } vec_t;

    vec_t vecs [12];
    logic [1:0] vm;
    logic       g;

    initial begin
        // Weighted fairness 0,1,1,0,1,1,0 then single-requester, burst-lock and backpressure cases.
        vecs[0]  = '{2'b11, 1'b0, 0, 0, 1'b0};
        vecs[1]  = '{2'b11, 1'b0, 0, 0, 1'b1};
        vecs[2]  = '{2'b11, 1'b0, 0, 0, 1'b1};
        vecs[3]  = '{2'b11, 1'b0, 0, 0, 1'b0};
        vecs[4]  = '{2'b11, 1'b0, 0, 0, 1'b1};
        vecs[5]  = '{2'b11, 1'b0, 0, 0, 1'b1};
        vecs[6]  = '{2'b11, 1'b0, 0, 0, 1'b0};
        vecs[7]  = '{2'b01, 1'b0, 0, 0, 1'b0};
        vecs[8]  = '{2'b10, 1'b1, 1, 4, 1'b1};
        vecs[9]  = '{2'b11, 1'b1, 0, 4, 1'b1};
        vecs[10] = '{2'b11, 1'b0, 0, 0, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 10, 0, 1'b1};

        rst_i       = 1'b1;
        cmd_valid   = 2'b00;
        cmd_write   = 2'b00;
        wvalid      = 2'b11;
        wlast       = 2'b00;
        s_cmd_ready = 1'b1;
        s_wready    = 1'b1;
        for (int r = 0; r < 2; r++) begin
            addr_m[r]  = ADDR_W'($urandom);
            len_m[r]   = LEN_W'($urandom);
            wdata_m[r] = {$urandom, $urandom, $urandom, $urandom};
        end
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_gnt", gnt_o, 1'b0);
        chk("rst_cmd_valid", s_cmd_valid_o, 1'b0);
        chk("rst_cmd_addr", s_cmd_addr_o, '0);
        chk("rst_wvalid", s_wvalid_o, 1'b0);
        chk("rst_wdata", s_wdata_o, '0);
        chk("rst_cmd_ready", m_cmd_ready_o, 2'b00);
        chk("rst_wready", m_wready_o, 2'b00);
        rst_i       = 1'b0;
        wvalid      = 2'b00;
        s_cmd_ready = 1'b0;
        s_wready    = 1'b0;

        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].vm, vecs[i].wr, vecs[i].stall, vecs[i].beats, vecs[i].exp_g);

        // Granted read whose valid drops while waiting in CMD.
        g = predict(2'b01);
        addr_m[0] = 28'h0001000;
        len_m[0]  = 8'd3;
        cmd_write = 2'b00;
        cmd_valid = 2'b01;
        @(negedge clk_i);
        chk("drop_gnt", s_cmd_id_o, 1'b0);
        cmd_valid  = 2'b00;
        drop_phase = 1'b1;
        #1;
        chk("drop_cmd_valid", s_cmd_valid_o, 1'b0);
        @(negedge clk_i);
        drop_phase = 1'b0;
        chk("drop_busy", busy_o, 1'b1);
        cmd_valid   = 2'b01;
        s_cmd_ready = 1'b1;
        #1;
        chk("drop_addr", s_cmd_addr_o, 28'h0001000);
        chk("drop_cmd_ready", m_cmd_ready_o, 2'b01);
        @(negedge clk_i);
        cmd_valid   = 2'b00;
        s_cmd_ready = 1'b0;
        #1;
        chk("drop_done", busy_o, 1'b0);
        model_done(g);

        // Write data offered before the command is accepted must wait for WDATA.
        g = predict(2'b01);
        cmd_write   = 2'b01;
        cmd_valid   = 2'b01;
        wvalid      = 2'b01;
        wlast       = 2'b01;
        wdata_m[0]  = {$urandom, $urandom, $urandom, $urandom};
        s_wready    = 1'b1;
        #1;
        chk("early_idle_wready", m_wready_o, 2'b00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("early_cmd_wready", m_wready_o, 2'b00);
            chk("early_cmd_swvalid", s_wvalid_o, 1'b0);
        end
        s_cmd_ready = 1'b1;
        #1;
        chk("early_hs_wready", m_wready_o, 2'b00);
        @(negedge clk_i);
        cmd_valid   = 2'b00;
        s_cmd_ready = 1'b0;
        #1;
        chk("early_beat_valid", s_wvalid_o, 1'b1);
        chk("early_beat_data", s_wdata_o, wdata_m[0]);
        chk("early_beat_wready", m_wready_o, 2'b01);
        @(negedge clk_i);
        wvalid   = 2'b00;
        wlast    = 2'b00;
        s_wready = 1'b0;
        #1;
        chk("early_done", busy_o, 1'b0);
        model_done(g);

        // Reset after two of four write beats from requester 1.
        cmd_write   = 2'b10;
        cmd_valid   = 2'b10;
        @(negedge clk_i);
        s_cmd_ready = 1'b1;
        @(negedge clk_i);
        cmd_valid   = 2'b00;
        s_cmd_ready = 1'b0;
        wvalid      = 2'b10;
        s_wready    = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rmw_busy", busy_o, 1'b0);
        chk("rmw_wvalid", s_wvalid_o, 1'b0);
        chk("rmw_wready", m_wready_o, 2'b00);
        chk("rmw_cmd_valid", s_cmd_valid_o, 1'b0);
        chk("rmw_cmd_ready", m_cmd_ready_o, 2'b00);
        rst_i    = 1'b0;
        wvalid   = 2'b00;
        s_wready = 1'b0;
        model_reset();
        run_txn(2'b01, 1'b0, 0, 0, 1'b0);
        run_txn(2'b11, 1'b0, 0, 0, predict(2'b11));

        // Randomized traffic; a losing requester keeps its command pending.
        for (int i = 0; i < 40; i++) begin
            vm = cmd_valid | 2'($urandom_range(0, 3));
            if (vm == 2'b00) vm = 2'b01;
            run_txn(vm, 1'($urandom), $urandom_range(0, 2), $urandom_range(1, 4), predict(vm));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hyper_titan_ddr_arb.md
Name: hyper_titan_ddr_arb

Overview:
- Two-requester arbiter sharing the single DDR3 controller command/write-data port between the E-core subsystem (requester 0) and the P-core subsystem (requester 1).
- Weighted round-robin at transaction granularity.
- Grant is held from command acceptance through the last write-data beat, so write bursts are never interleaved.
- Read data return is routed downstream by the forwarded requester ID and is out of scope.

Parameters:
- ADDR_W, 28: command address width.
- DATA_W, 128: write data width.
- LEN_W, 8: burst length field width (beats minus 1).
- WEIGHT_0, 1: consecutive transactions requester 0 may win while holding preference (0 treated as 1).
- WEIGHT_1, 2: same for requester 1 (0 treated as 1).
- CNT_W, 4: width of the internal weight counter; WEIGHT_x must be < 2^CNT_W.

Ports:
- clk_i  in  1  block clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m_cmd_valid_i  in  2  per-requester command valid.
- m_cmd_ready_o  out  2  per-requester command ready.
- m_cmd_addr_i  in  2xADDR_W  command address.
- m_cmd_write_i  in  2  1 = write, 0 = read.
- m_cmd_len_i  in  2xLEN_W  beats minus 1.
- m_wvalid_i  in  2  write data valid.
- m_wready_o  out  2  write data ready.
- m_wdata_i  in  2xDATA_W  write data.
- m_wlast_i  in  2  last write beat.
- s_cmd_valid_o  out  1  command valid to the DDR controller.
- s_cmd_ready_i  in  1  command ready from the DDR controller.
- s_cmd_addr_o, s_cmd_write_o, s_cmd_len_o  out  ADDR_W / 1 / LEN_W  forwarded command fields.
- s_cmd_id_o  out  1  index of the granted requester.
- s_wvalid_o  out  1  write valid to the controller.
- s_wready_i  in  1  write ready from the controller.
- s_wdata_o  out  DATA_W  forwarded write data.
- s_wlast_o  out  1  forwarded last-beat flag.
- gnt_o  out  1  currently granted requester.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- Reset: state=IDLE, gnt=0, pref=0, cnt=0.
  - All valid and ready outputs are 0; s_* data fields are 0; busy_o=0.
  - Reset asserted mid-burst aborts the transaction immediately, with no completion bookkeeping.
- State IDLE:
  - No requester valid: remain in IDLE.
  - Both valid: gnt <= pref.
  - Exactly one valid: gnt <= that requester.
  - Any grant moves to CMD. Arbitration latency is 1 cycle, so s_cmd_valid_o is first high the cycle after m_cmd_valid_i is seen in IDLE.
- State CMD:
  - s_cmd_valid_o = m_cmd_valid_i[gnt]; address, write and len fields pass through combinationally.
  - s_cmd_id_o = gnt.
  - m_cmd_ready_o[gnt] = s_cmd_ready_i; the non-granted ready is 0.
  - On handshake: write goes to WDATA; read completes and goes to IDLE.
  - Requesters must hold valid until ready. A dropped valid leaves the state in CMD; the bench checks this with an assertion.
- State WDATA:
  - s_w* mirror m_w*[gnt]; m_wready_o[gnt] = s_wready_i.
  - Non-granted wready is 0 in all states, and write data offered before WDATA is never accepted.
  - A handshake with wlast completes the transaction and returns to IDLE. Beat count is not checked against len; wlast alone terminates.
- Completion bookkeeping, for granted requester g at completion:
  - c = (g==pref) ? cnt+1 : 1.
  - If c >= WEIGHT_g: pref <= ~g, cnt <= 0.
  - Otherwise: pref <= g, cnt <= c.
- Throughput: minimum of 1 idle cycle (the IDLE arbitration cycle) between back-to-back transactions.
- A new m_cmd_valid_i arriving on the completing cycle is considered in the following IDLE cycle.
- gnt_o = gnt; it holds its last value in IDLE.

Test Plan:
- Reset mid-write: reset after 2 of 4 write beats from req1. Required: next cycle state=IDLE, all valid/ready outputs 0, pref=0. req0 read issued afterwards is granted normally.
- Single requester read: req0 read, addr 0x0001000, len 3, s_cmd_ready_i=1. Required: s_cmd_valid_o high 1 cycle after request, s_cmd_id_o=0, m_cmd_ready_o=2'b01 for 1 cycle, busy_o returns to 0.
- Write burst lock: req1 write, len 3, 4 beats with s_wready_i toggling. req0 asserts a read throughout. Required: all 4 beats forwarded with the same data order, m_wready_o[0]=0 throughout, req0 granted only after the wlast handshake.
- Weighted fairness: both requesters continuously issue reads, WEIGHT_0=1, WEIGHT_1=2. Required: grant sequence 0,1,1,0,1,1,0 over 7 transactions.
- Backpressure: s_cmd_ready_i=0 for 10 cycles during CMD. Required: s_cmd_* stable, no ready to either requester, no grant change.
- Early wdata: req0 asserts wvalid 3 cycles before its write command is accepted. Required: m_wready_o[0]=0 until WDATA; first beat is forwarded on the cycle after the command handshake when s_wready_i=1.
